// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the UART receive path and host-command
// decoder: byte FSM and frame FSM state enums, opcode values and the
// default frame header.
// Optional build macro: UART_RX_PARITY_EN adds a PARITY state to the
// byte FSM (8E1 framing instead of 8N1).
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_PARITY,
    BYTE_STOP
  } byte_state_t;
`else
  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP
  } byte_state_t;
`endif

  typedef enum logic [1:0] {
    FRM_WAIT_HDR,
    FRM_WAIT_OP,
    FRM_WAIT_CHK
  } frame_state_t;

  localparam logic [7:0] OP_START         = 8'h01;
  localparam logic [7:0] OP_STOP          = 8'h02;
  localparam logic [7:0] OP_TOGGLE        = 8'h03;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'h55;

  // Clocks per bit, integer-truncated.
  function automatic int bit_count(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Two-flop synchroniser plus byte deserialiser. Detects the start-bit
// falling edge, confirms it at mid start bit, samples the data bits
// LSB first at mid-bit and checks the stop bit.
// Optional build macro: UART_RX_PARITY_EN inserts an even-parity bit
// between the data and stop bits; a parity mismatch is reported as a
// framing error.
// Ports:
//   clk           receive clock
//   rst           asynchronous active-high reset
//   rx_data       serial line, idle high, asynchronous to clk
//   paralle_data  last correctly received byte
//   rx_valid      one-cycle pulse, paralle_data just updated
//   frame_err     one-cycle pulse, bad stop bit (or bad parity)
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic [7:0] paralle_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int BIT_CNT = bit_count(CLK_FREQ, BAUD);
  localparam int CNT_W   = $clog2(BIT_CNT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CNT - 1);

  byte_state_t state, state_next;

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             start_edge;
  logic             bit_end;
  logic             byte_good;

  // Line synchroniser; rx_prev holds the previous synchronised value so
  // a start edge is a 1 -> 0 step on the clean signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;
  assign bit_end    = (cnt == FULL_LAST);

`ifdef UART_RX_PARITY_EN
  logic parity_ok;

  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_ok <= 1'b1;
    end else if (state == BYTE_PARITY && bit_end) begin
      parity_ok <= ~(^shift ^ rx_s);
    end
  end

  assign byte_good = rx_s & parity_ok;
`else
  assign byte_good = rx_s;
`endif

  // Byte FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BYTE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte FSM next state. A start edge that is high again at mid start
  // bit is treated as a glitch and silently dropped.
  always_comb begin
    state_next = state;
    case (state)
      BYTE_IDLE: begin
        if (start_edge) state_next = BYTE_START;
      end
      BYTE_START: begin
        if (cnt == HALF_LAST) state_next = rx_s ? BYTE_IDLE : BYTE_DATA;
      end
      BYTE_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = BYTE_PARITY;
`else
          state_next = BYTE_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      BYTE_PARITY: begin
        if (bit_end) state_next = BYTE_PARITY == state ? BYTE_STOP : state;
      end
`endif
      BYTE_STOP: begin
        if (bit_end) state_next = BYTE_IDLE;
      end
      default: state_next = BYTE_IDLE;
    endcase
  end

  // Bit timer restarts on every state change and at each data-bit
  // boundary, so sampling lands mid-bit relative to the start-bit centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (state_next != state || state == BYTE_IDLE ||
          (state == BYTE_DATA && bit_end)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == BYTE_START) begin
        bit_idx <= '0;
      end else if (state == BYTE_DATA && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == BYTE_DATA && bit_end) begin
        shift <= {rx_s, shift[7:1]};
      end
    end
  end

  // Stop-bit decision: publish the byte or flag a framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paralle_data <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == BYTE_STOP && bit_end) begin
        if (byte_good) begin
          paralle_data <= shift;
          rx_valid     <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd
// UART receiver and host-command decoder. Frames are HDR, opcode,
// ~opcode. A valid frame starts, stops or toggles the acquisition
// enable level `command`; bad checksums, unknown opcodes, framing
// errors inside a frame and inter-byte timeouts pulse cmd_err.
// Optional build macro: UART_RX_PARITY_EN (8E1 framing in uart_rx_byte).
// Ports:
//   sysclk_12     12 MHz UART clock
//   i_rest        asynchronous active-high reset
//   rx_data       serial line from host, idle high
//   paralle_data  last received byte
//   rx_valid      one-cycle pulse, paralle_data updated
//   frame_err     one-cycle pulse, bad stop bit
//   command       acquisition enable: 1 = run, 0 = stop
//   cmd_err       one-cycle pulse, bad frame
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 12000000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT,
  parameter int         TIMEOUT_BITS = 40
) (
  input  logic       sysclk_12,
  input  logic       i_rest,
  input  logic       rx_data,
  output logic [7:0] paralle_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       command,
  output logic       cmd_err
);

  localparam int BIT_CNT  = bit_count(CLK_FREQ, BAUD);
  localparam int TOUT_CLK = TIMEOUT_BITS * BIT_CNT;
  localparam int TOUT_W   = $clog2(TOUT_CLK + 1);
  localparam logic [TOUT_W-1:0] TOUT_LIM = TOUT_W'(TOUT_CLK);

  frame_state_t      frm, frm_next;
  logic [7:0]        opcode;
  logic              opcode_load;
  logic              command_next;
  logic              cmd_err_next;
  logic [TOUT_W-1:0] idle_cnt;
  logic              timeout;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte (
    .clk          (sysclk_12),
    .rst          (i_rest),
    .rx_data      (rx_data),
    .paralle_data (paralle_data),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err)
  );

  // Inter-byte idle counter: only runs mid-frame, clears on each byte,
  // and holds at the limit instead of wrapping.
  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      idle_cnt <= '0;
    end else if (rx_valid || frm == FRM_WAIT_HDR) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TOUT_LIM) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = (idle_cnt == TOUT_LIM);

  // Frame FSM, opcode latch and registered outputs.
  always_ff @(posedge sysclk_12 or posedge i_rest) begin
    if (i_rest) begin
      frm     <= FRM_WAIT_HDR;
      opcode  <= '0;
      command <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      frm     <= frm_next;
      command <= command_next;
      cmd_err <= cmd_err_next;
      if (opcode_load) opcode <= paralle_data;
    end
  end

  // Frame FSM next state. A received byte takes priority over a timeout
  // or framing error in the same cycle.
  always_comb begin
    frm_next     = frm;
    command_next = command;
    cmd_err_next = 1'b0;
    opcode_load  = 1'b0;
    case (frm)
      FRM_WAIT_HDR: begin
        if (rx_valid && paralle_data == HDR_BYTE) frm_next = FRM_WAIT_OP;
      end
      FRM_WAIT_OP: begin
        if (rx_valid) begin
          opcode_load = 1'b1;
          frm_next    = FRM_WAIT_CHK;
        end else if (frame_err || timeout) begin
          cmd_err_next = 1'b1;
          frm_next     = FRM_WAIT_HDR;
        end
      end
      FRM_WAIT_CHK: begin
        if (rx_valid) begin
          frm_next = FRM_WAIT_HDR;
          if (paralle_data == ~opcode) begin
            case (opcode)
              OP_START:  command_next = 1'b1;
              OP_STOP:   command_next = 1'b0;
              OP_TOGGLE: command_next = ~command;
              default:   cmd_err_next = 1'b1;
            endcase
          end else begin
            cmd_err_next = 1'b1;
          end
        end else if (frame_err || timeout) begin
          cmd_err_next = 1'b1;
          frm_next     = FRM_WAIT_HDR;
        end
      end
      default: frm_next = FRM_WAIT_HDR;
    endcase
  end

endmodule
